// File: rtl/mem_access_master.sv
// Byte-serial initiator: replays one 32-bit or byte load/store as single-byte strobe beats
// (one strobe-high cycle, one strobe-low cycle each) and assembles read bytes little-endian.
module mem_access_master #(
    parameter int N          = 32,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 8192
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic                  req_byte_i,
    input  logic [N-1:0]          req_addr_i,
    input  logic [N-1:0]          req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [N-1:0]          rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [N-1:0]          mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_read_enable_o,
    output logic                  mem_write_enable_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int BEATS = N / DATA_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, last_q;
    logic                  write_q, err_q, err_d;
    logic                  rsp_err_q;
    logic [N-1:0]          base_q, wdata_q, asm_q, asm_d, rsp_rdata_q;
    logic [N-1:0]          beat_addr;
    logic                  in_range, accept, last_beat;
    logic [DATA_WIDTH-1:0] lane_wdata;

    assign accept     = req_valid_i && (state_q == IDLE);
    assign beat_addr  = base_q + N'(beat_q);
    assign in_range   = beat_addr < N'(MEM_DEPTH);
    assign last_beat  = (beat_q == last_q);
    assign lane_wdata = wdata_q[beat_q*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = last_beat ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o        = 1'b0;
        rsp_valid_o        = 1'b0;
        mem_addr_o         = '0;
        mem_wdata_o        = '0;
        mem_read_enable_o  = 1'b0;
        mem_write_enable_o = 1'b0;
        case (state_q)
            IDLE:    req_ready_o = 1'b1;
            ISSUE: begin
                mem_addr_o         = beat_addr;
                mem_wdata_o        = lane_wdata;
                mem_read_enable_o  = !write_q && in_range;
                mem_write_enable_o = write_q && in_range;
            end
            CAPTURE: begin
                mem_addr_o  = beat_addr;
                mem_wdata_o = lane_wdata;
            end
            DONE:    rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // Out-of-range load beats contribute zero, never the stale memory byte.
    always_comb begin
        asm_d = asm_q;
        err_d = err_q | ~in_range;
        if (!write_q)
            asm_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = in_range ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            beat_q      <= '0;
            last_q      <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    beat_q  <= '0;
                    last_q  <= req_byte_i ? '0 : BW'(BEATS - 1);
                    write_q <= req_write_i;
                    err_q   <= 1'b0;
                end
                CAPTURE: begin
                    err_q <= err_d;
                    if (last_beat) begin
                        rsp_rdata_q <= write_q ? '0 : asm_d;
                        rsp_err_q   <= err_d;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && accept) begin
            base_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            asm_q   <= '0;
        end else if (state_q == CAPTURE) begin
            asm_q <= asm_d;
        end
    end
endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench for mem_access_master: byte-array reference model, randomized requests,
// strobe/response monitors decoupled from stimulus.
module tb_mem_access_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_byte = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata = '0;
    logic        mem_read_enable, mem_write_enable;

    mem_access_master #(.N(32), .DATA_WIDTH(8), .MEM_DEPTH(8192)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_byte_i(req_byte),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_read_enable_o(mem_read_enable), .mem_write_enable_o(mem_write_enable),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] tb_mem  [0:8191];
    logic [7:0] ref_mem [0:8191];

    // Memory latches on the strobe edge; read data is held until the next read.
    always @(posedge clk) begin
        if (mem_write_enable) tb_mem[mem_addr[12:0]] <= mem_wdata;
        if (mem_read_enable)  mem_rdata <= tb_mem[mem_addr[12:0]];
    end

    typedef struct {int cyc; logic [31:0] addr; bit wr; logic [7:0] data;} beat_t;
    typedef struct {int cyc; logic [31:0] rdata; bit err;} rsp_t;
    beat_t beat_q[$];
    rsp_t  rsp_q[$];

    int total = 0, bad = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    beat_t b;
    rsp_t  r;
    bit    prev_stb = 1'b0, prev_rsp = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stb = 1'b0;
            prev_rsp = 1'b0;
        end else begin
            if (mem_read_enable || mem_write_enable) begin
                chk("strobe_exclusive", {31'b0, mem_read_enable & mem_write_enable}, 32'd0);
                chk("strobe_gap", {31'b0, prev_stb}, 32'd0);
                if (beat_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_strobe: addr %h at cycle %0d, none expected", mem_addr, cyc);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_cycle", cyc, b.cyc);
                    chk("beat_addr", mem_addr, b.addr);
                    chk("beat_dir", {31'b0, mem_write_enable}, {31'b0, b.wr});
                    if (b.wr) chk("beat_wdata", {24'b0, mem_wdata}, {24'b0, b.data});
                end
            end
            if (rsp_valid) begin
                chk("rsp_gap", {31'b0, prev_rsp}, 32'd0);
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: rdata %h at cycle %0d, none expected", rsp_rdata, cyc);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_cycle", cyc, r.cyc);
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
                end
            end
            prev_stb = mem_read_enable || mem_write_enable;
            prev_rsp = rsp_valid;
        end
    end

    // Present a request at a negedge and wait for acceptance. Only the first `keep`
    // beats are expected (used when a reset will cut the transaction short).
    task automatic issue(input bit wr, input bit by, input logic [31:0] a, input logic [31:0] d,
                         input int keep, input bit hold, output int p);
        logic [31:0] ba, rd;
        bit          err;
        int          last, n;
        req_valid = 1'b1; req_write = wr; req_byte = by; req_addr = a; req_wdata = d;
        for (n = 0; n < 100; n++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        if (n == 100) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready %b, required 1 within 100 cycles", req_ready);
            req_valid = 1'b0;
            p = -1;
            return;
        end
        p = cyc;
        last = by ? 0 : 3;
        rd = '0;
        err = 1'b0;
        for (int k = 0; k <= last; k++) begin
            ba = a + 32'(k);
            if (ba < 32'd8192) begin
                if (k < keep) beat_q.push_back('{p + 1 + 2 * k, ba, wr, d[8*k +: 8]});
                if (wr && k < keep) ref_mem[ba[12:0]] = d[8*k +: 8];
                else if (!wr)       rd[8*k +: 8] = ref_mem[ba[12:0]];
            end else begin
                err = 1'b1;
            end
        end
        if (keep > last) rsp_q.push_back('{p + (by ? 3 : 9), wr ? 32'd0 : rd, err});
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 200; n++) begin
            if (rsp_q.size() == 0 && beat_q.size() == 0) break;
            @(negedge clk);
        end
        if (n == 200) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d responses and %0d beats still pending, required 0",
                     rsp_q.size(), beat_q.size());
            rsp_q.delete();
            beat_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int p, p1, p2, p3;
        logic [31:0] a, d;
        for (int i = 0; i < 8192; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_strobes", {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        tb_mem[45] = 8'hA5; ref_mem[45] = 8'hA5;
        issue(1'b0, 1'b1, 32'd45, 32'd0, 4, 1'b0, p);
        drain();
        chk("byte_load_value", last_rdata, 32'h000000A5);

        tb_mem[0] = 8'h11; tb_mem[1] = 8'h22; tb_mem[2] = 8'h33; tb_mem[3] = 8'h44;
        ref_mem[0] = 8'h11; ref_mem[1] = 8'h22; ref_mem[2] = 8'h33; ref_mem[3] = 8'h44;
        issue(1'b0, 1'b0, 32'd0, 32'd0, 4, 1'b0, p);
        drain();
        chk("word_load_value", last_rdata, 32'h44332211);

        issue(1'b1, 1'b0, 32'd100, 32'hDEADBEEF, 4, 1'b0, p);
        drain();
        chk("store_rdata_zero", last_rdata, 32'd0);
        issue(1'b0, 1'b0, 32'd100, 32'd0, 4, 1'b0, p);
        drain();
        chk("store_readback", last_rdata, 32'hDEADBEEF);

        issue(1'b0, 1'b0, 32'd8190, 32'd0, 4, 1'b0, p);
        drain();
        chk("edge_upper_zero", {16'b0, last_rdata[31:16]}, 32'd0);
        chk("edge_word_err", {31'b0, last_err}, 32'd1);
        issue(1'b0, 1'b1, 32'd8191, 32'd0, 4, 1'b0, p);
        drain();
        chk("edge_byte_err", {31'b0, last_err}, 32'd0);

        for (int i = 200; i < 204; i++) begin tb_mem[i] = 8'h5A; ref_mem[i] = 8'h5A; end
        issue(1'b1, 1'b0, 32'd200, 32'h87654321, 2, 1'b0, p);
        while (cyc < p + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_beat0", {24'b0, tb_mem[200]}, 32'h21);
        chk("abort_beat1", {24'b0, tb_mem[201]}, 32'h43);
        chk("abort_beat2", {24'b0, tb_mem[202]}, 32'h5A);
        chk("abort_beat3", {24'b0, tb_mem[203]}, 32'h5A);
        chk("abort_pending", beat_q.size() + rsp_q.size(), 32'd0);

        issue(1'b0, 1'b0, 32'd0, 32'd0, 4, 1'b1, p1);
        issue(1'b0, 1'b0, 32'd4, 32'd0, 4, 1'b1, p2);
        issue(1'b0, 1'b1, 32'd45, 32'd0, 4, 1'b0, p3);
        chk("b2b_word_accept", p2, p1 + 10);
        chk("b2b_byte_accept", p3, p2 + 10);
        drain();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: a = $urandom_range(0, 8191);
                2:    a = $urandom_range(8186, 8191);
                default: a = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF - $urandom_range(0, 3)
                                                         : $urandom_range(8192, 9000);
            endcase
            d = $urandom;
            issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d, 4,
                  $urandom_range(0, 1) == 1, p);
        end
        req_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
